// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, widths and defaults for the pong game controller
package pong_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_MISS    = 3'd3,
    ST_OVER    = 3'd4
  } pong_state_e;

  localparam int BCD_W              = 4;
  localparam int DEF_LIVES          = 3;
  localparam int DEF_SERVE_FRAMES   = 60;
  localparam int DEF_MISS_FRAMES    = 30;
  localparam int DEF_HITS_PER_LEVEL = 4;
  localparam int FLASH_FRAMES       = 16;

  // One counter serves SERVE, MISS and the OVER blink, so size it for the longest.
  function automatic int frame_cnt_w(input int serve_frames, input int miss_frames);
    int m;
    m = (serve_frames > miss_frames) ? serve_frames : miss_frames;
    if (m < FLASH_FRAMES) m = FLASH_FRAMES;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// rtl/pong_bcd_score.sv - two-digit BCD score counter saturating at 99
module pong_bcd_score
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (inc) begin
      if (r_ones == BCD_W'(9)) begin
        if (r_tens != BCD_W'(9)) begin
          r_ones <= '0;
          r_tens <= r_tens + BCD_W'(1);
        end
      end else begin
        r_ones <= r_ones + BCD_W'(1);
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencing: serve, play, miss, game over, score and speed
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES          = DEF_LIVES,
  parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES,
  parameter int MISS_FRAMES    = DEF_MISS_FRAMES,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_start,
  input  logic             ball_hit,
  input  logic             ball_miss,
  output logic             phys_en,
  output logic             phys_load,
  output logic [1:0]       speed_level,
  output logic [BCD_W-1:0] score_tens,
  output logic [BCD_W-1:0] score_ones,
  output logic [1:0]       lives,
  output logic [2:0]       state,
  output logic             flash
);

  localparam int CNT_W = frame_cnt_w(SERVE_FRAMES, MISS_FRAMES);
  localparam int HC_W  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  pong_state_e      r_state;
  logic             r_btn_prev;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [HC_W-1:0]  r_hit_cnt;
  logic             r_phys_en;
  logic             r_phys_load;
  logic [1:0]       r_speed;
  logic [1:0]       r_lives;
  logic             r_flash;
  logic             r_score_clr;

  logic w_start;
  logic w_score_inc;

  assign w_start     = btn_start & ~r_btn_prev;
  // A simultaneous miss wins, so the hit never reaches the score.
  assign w_score_inc = (r_state == ST_PLAY) & ball_hit & ~ball_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Previous value resets high so a button held through reset is not a press.
      r_btn_prev  <= 1'b1;
      r_state     <= ST_ATTRACT;
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
      r_phys_en   <= 1'b0;
      r_phys_load <= 1'b0;
      r_speed     <= 2'd0;
      r_lives     <= 2'd0;
      r_flash     <= 1'b0;
      r_score_clr <= 1'b0;
    end else begin
      r_btn_prev  <= btn_start;
      r_phys_load <= 1'b0;
      r_score_clr <= 1'b0;
      case (r_state)
        ST_ATTRACT: begin
          r_phys_en <= 1'b0;
          r_flash   <= 1'b0;
          if (w_start) begin
            r_state     <= ST_SERVE;
            r_lives     <= 2'(LIVES);
            r_speed     <= 2'd0;
            r_hit_cnt   <= '0;
            r_frame_cnt <= '0;
            r_phys_load <= 1'b1;
            r_score_clr <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (r_frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              r_state     <= ST_PLAY;
              r_phys_en   <= 1'b1;
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (ball_miss) begin
            r_state     <= ST_MISS;
            r_phys_en   <= 1'b0;
            r_frame_cnt <= '0;
            r_lives     <= r_lives - 2'd1;
          end else if (ball_hit) begin
            if (r_hit_cnt == HC_W'(HITS_PER_LEVEL - 1)) begin
              r_hit_cnt <= '0;
              if (r_speed != 2'd3) r_speed <= r_speed + 2'd1;
            end else begin
              r_hit_cnt <= r_hit_cnt + HC_W'(1);
            end
          end
        end
        ST_MISS: begin
          if (frame_tick) begin
            if (r_frame_cnt == CNT_W'(MISS_FRAMES - 1)) begin
              r_frame_cnt <= '0;
              if (r_lives == 2'd0) begin
                r_state <= ST_OVER;
              end else begin
                r_state     <= ST_SERVE;
                r_phys_load <= 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end
        end
        ST_OVER: begin
          if (w_start) begin
            r_state     <= ST_ATTRACT;
            r_flash     <= 1'b0;
            r_frame_cnt <= '0;
          end else if (frame_tick) begin
            if (r_frame_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
              r_frame_cnt <= '0;
              r_flash     <= ~r_flash;
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state     <= ST_ATTRACT;
          r_phys_en   <= 1'b0;
          r_flash     <= 1'b0;
          r_frame_cnt <= '0;
        end
      endcase
    end
  end

  pong_bcd_score u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_score_clr),
    .inc   (w_score_inc),
    .tens  (score_tens),
    .ones  (score_ones)
  );

  assign phys_en     = r_phys_en;
  assign phys_load   = r_phys_load;
  assign speed_level = r_speed;
  assign lives       = r_lives;
  assign state       = r_state;
  assign flash       = r_flash;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_start;
  logic       ball_hit;
  logic       ball_miss;
  logic       phys_en;
  logic       phys_load;
  logic [1:0] speed_level;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] lives;
  logic [2:0] state;
  logic       flash;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .btn_start   (btn_start),
    .ball_hit    (ball_hit),
    .ball_miss   (ball_miss),
    .phys_en     (phys_en),
    .phys_load   (phys_load),
    .speed_level (speed_level),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .lives       (lives),
    .state       (state),
    .flash       (flash)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    step(n);
    frame_tick = 1'b0;
  endtask

  task automatic hits(input int n);
    ball_hit = 1'b1;
    step(n);
    ball_hit = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_score(input string tag, input int t, input int o);
    chk({tag, "_tens"}, 32'(score_tens), 32'(t));
    chk({tag, "_ones"}, 32'(score_ones), 32'(o));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_phys_en"}, 32'(phys_en), 0);
    chk({tag, "_phys_load"}, 32'(phys_load), 0);
    chk({tag, "_speed"}, 32'(speed_level), 0);
    chk({tag, "_lives"}, 32'(lives), 0);
    chk({tag, "_flash"}, 32'(flash), 0);
    chk_score(tag, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; ball_hit = 1'b0; ball_miss = 1'b0;
    step(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step(2);
    chk("idle_state", 32'(state), 0);

    btn_start = 1'b1;
    step(1);
    chk("start_state", 32'(state), 1);
    chk("start_load", 32'(phys_load), 1);
    chk("start_lives", 32'(lives), 3);
    chk_score("start", 0, 0);
    step(1);
    chk("load_one_cycle", 32'(phys_load), 0);
    btn_start = 1'b0;

    ball_hit = 1'b1; ball_miss = 1'b1;
    step(1);
    ball_hit = 1'b0; ball_miss = 1'b0;
    chk("serve_ignore_state", 32'(state), 1);
    chk("serve_ignore_lives", 32'(lives), 3);
    chk_score("serve_ignore", 0, 0);

    ticks(59);
    chk("serve_59", 32'(state), 1);
    chk("serve_59_en", 32'(phys_en), 0);
    ticks(1);
    chk("serve_60", 32'(state), 2);
    chk("serve_60_en", 32'(phys_en), 1);

    hits(3);
    chk("h3_speed", 32'(speed_level), 0);
    hits(1);
    chk("h4_speed", 32'(speed_level), 1);
    chk_score("h4", 0, 4);
    hits(1);
    chk_score("h5", 0, 5);

    ball_hit = 1'b1; ball_miss = 1'b1;
    step(1);
    ball_hit = 1'b0; ball_miss = 1'b0;
    chk("both_state", 32'(state), 3);
    chk("both_lives", 32'(lives), 2);
    chk("both_en", 32'(phys_en), 0);
    chk_score("both", 0, 5);

    ticks(29);
    chk("miss_29", 32'(state), 3);
    ticks(1);
    chk("miss_30", 32'(state), 1);
    chk("miss_30_load", 32'(phys_load), 1);
    ticks(60);
    chk("serve2", 32'(state), 2);

    hits(2);
    chk("g2_h2_speed", 32'(speed_level), 1);
    chk_score("g2_h2", 0, 7);
    hits(1);
    chk("g2_h3_speed", 32'(speed_level), 2);
    hits(1);
    chk_score("g2_09", 0, 9);
    hits(1);
    chk_score("g2_10", 1, 0);
    hits(2);
    chk("g2_12_speed", 32'(speed_level), 3);
    chk_score("g2_12", 1, 2);
    hits(4);
    chk("g2_16_speed", 32'(speed_level), 3);
    chk_score("g2_16", 1, 6);

    ball_miss = 1'b1; step(1); ball_miss = 1'b0;
    chk("miss2_lives", 32'(lives), 1);
    ticks(30);
    ticks(60);
    chk("serve3_state", 32'(state), 2);
    chk("serve3_speed_kept", 32'(speed_level), 3);
    ball_miss = 1'b1; step(1); ball_miss = 1'b0;
    chk("miss3_lives", 32'(lives), 0);
    ticks(30);
    chk("over_state", 32'(state), 4);
    chk("over_load", 32'(phys_load), 0);
    chk("over_flash0", 32'(flash), 0);
    ticks(15);
    chk("flash_15", 32'(flash), 0);
    ticks(1);
    chk("flash_16", 32'(flash), 1);
    ticks(16);
    chk("flash_32", 32'(flash), 0);
    ticks(16);
    chk("flash_48", 32'(flash), 1);
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    chk("over_exit_state", 32'(state), 0);
    chk("over_exit_flash", 32'(flash), 0);
    step(1);

    btn_start = 1'b1;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("held_state_a", 32'(state), 0);
    step(3);
    chk("held_state_b", 32'(state), 0);
    btn_start = 1'b0;
    step(1);
    btn_start = 1'b1;
    step(1);
    chk("repress_state", 32'(state), 1);
    chk_score("repress", 0, 0);
    btn_start = 1'b0;

    ticks(60);
    chk("g3_play", 32'(state), 2);
    hits(99);
    chk_score("sat_99", 9, 9);
    hits(1);
    chk_score("sat_100", 9, 9);

    rst_n = 1'b0; frame_tick = 1'b1; ball_hit = 1'b1;
    step(1);
    frame_tick = 1'b0; ball_hit = 1'b0;
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
